// File: rtl/param_register_file_if.sv
// Bundle of the register file's clear, write, read and debug signals.
// master drives requests and addresses; slave is the register file.
interface param_register_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     clr;
    logic                     busy;
    logic                     wr_ready;
    logic                     we;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0]        dbg_addr;
    logic [DATA_W-1:0]        dbg_data;

    modport master (
        output clr, we, wr_addr, wr_data, rd_addr, dbg_addr,
        input  busy, wr_ready, rd_data, dbg_data
    );

    modport slave (
        input  clr, we, wr_addr, wr_data, rd_addr, dbg_addr,
        output busy, wr_ready, rd_data, dbg_data
    );
endinterface

// File: rtl/param_register_file.sv
// Multi-read-port register file with write-through bypass; cleared by a DEPTH-cycle sweep after reset or clr.
// Latency: writes commit at posedge, reads combinational (0-cycle bypass). Optional macro RF_ZERO_REG_EN hardwires entry 0 to 0.
// Backpressure: wr_ready=0 during the sweep; writes presented then are dropped, not queued.
module param_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    param_register_file_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] sweep_idx, sweep_idx_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              busy;
    logic              wr_acc;
    logic              wr_store;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CLEAR;
            sweep_idx <= '0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= sweep_idx_nxt;
        end
    end

    // clr during CLEAR is deliberately ignored so a sweep always runs to completion
    always_comb begin
        state_nxt     = state;
        sweep_idx_nxt = sweep_idx;
        case (state)
            CLEAR: begin
                if (sweep_idx == ADDR_W'(DEPTH - 1)) begin
                    state_nxt     = IDLE;
                    sweep_idx_nxt = '0;
                end else begin
                    sweep_idx_nxt = sweep_idx + 1'b1;
                end
            end
            IDLE: begin
                if (bus.clr) begin
                    state_nxt     = CLEAR;
                    sweep_idx_nxt = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign busy         = (state == CLEAR);
    assign bus.busy     = busy;
    assign bus.wr_ready = ~busy;
    assign wr_acc       = bus.we && !busy;

`ifdef RF_ZERO_REG_EN
    assign wr_store = wr_acc && !bus.clr && (bus.wr_addr != '0);
`else
    assign wr_store = wr_acc && !bus.clr;
`endif

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[sweep_idx] <= '0;
        end else if (wr_store) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            if (busy) begin
                rd = '0;
            end else if (wr_acc && (bus.wr_addr == ra)) begin
                rd = bus.wr_data;
            end else begin
                rd = mem[ra];
            end
`ifdef RF_ZERO_REG_EN
            if (ra == '0) begin
                rd = '0;
            end
`endif
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = rd;
    end

`ifdef RF_ZERO_REG_EN
    assign bus.dbg_data = (bus.dbg_addr == '0) ? '0 : mem[bus.dbg_addr];
`else
    assign bus.dbg_data = mem[bus.dbg_addr];
`endif
endmodule

// File: tb/tb_param_register_file.sv
// Randomized self-checking bench for param_register_file (DATA_W=32, ADDR_W=5, NUM_RD=4).
module tb_param_register_file;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int DEPTH = 1 << AW;
`ifdef RF_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [DW-1:0] model [DEPTH];

    param_register_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    param_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit w,
                                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (ZERO && a == 0) return '0;
        if (w && wa == a) return wd;
        return model[a];
    endfunction

    // Drives random traffic while busy; returns busy sample count and cycles with unmasked outputs.
    task automatic wait_sweep(input int clr_at, output int n, output int bad);
        n = 0;
        bad = 0;
        while (bus.busy && n < 200) begin
            if (bus.wr_ready !== 1'b0 || bus.rd_data !== '0) bad++;
            bus.we      = 1'($urandom);
            bus.wr_addr = AW'($urandom);
            bus.wr_data = $urandom;
            bus.rd_addr = (NR*AW)'($urandom);
            bus.clr     = (n == clr_at);
            @(negedge clk);
            n++;
        end
        bus.we  = 1'b0;
        bus.clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic test_reset();
        int n, bad;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state busy=%b wr_ready=%b required busy=1 wr_ready=0", bus.busy, bus.wr_ready);
        end
        rst = 1'b1;
        wait_sweep(-1, n, bad);
        n_cmp++;
        if (n !== 32) begin
            n_err++;
            $display("FAIL reset_sweep_len got %0d required 32", n);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL reset_busy_mask got %0d bad cycles required 0", bad);
        end
        for (int a = 0; a < DEPTH; a++) begin
            bus.dbg_addr = AW'(a);
            #1;
            n_cmp++;
            if (bus.dbg_data !== '0) begin
                n_err++;
                $display("FAIL reset_dbg addr=%0d got %h required 0", a, bus.dbg_data);
            end
        end
    endtask

    task automatic test_bypass();
        bus.we = 1'b1; bus.wr_addr = 5'd11; bus.wr_data = 32'hDEAD_BEEF;
        bus.rd_addr = '0; bus.rd_addr[0 +: AW] = 5'd11; bus.dbg_addr = 5'd11;
        #1;
        n_cmp++;
        if (bus.rd_data[0 +: DW] !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL bypass_rd0 got %h required deadbeef", bus.rd_data[0 +: DW]);
        end
        n_cmp++;
        if (bus.dbg_data !== model[11]) begin
            n_err++;
            $display("FAIL bypass_dbg_pre got %h required %h", bus.dbg_data, model[11]);
        end
        @(negedge clk);
        bus.we = 1'b0;
        model[11] = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if (bus.dbg_data !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL bypass_dbg_post got %h required deadbeef", bus.dbg_data);
        end
    endtask

    task automatic test_multi_port();
        bus.we = 1'b1; bus.wr_addr = 5'd13; bus.wr_data = 32'h5A5A;
        @(negedge clk);
        bus.we = 1'b0;
        model[13] = 32'h5A5A;
        for (int k = 0; k < NR; k++) bus.rd_addr[k*AW +: AW] = 5'd13;
        #1;
        for (int k = 0; k < NR; k++) begin
            n_cmp++;
            if (bus.rd_data[k*DW +: DW] !== 32'h5A5A) begin
                n_err++;
                $display("FAIL multi_port%0d got %h required 00005a5a", k, bus.rd_data[k*DW +: DW]);
            end
        end
        bus.rd_addr[1*AW +: AW] = 5'd12;
        #1;
        n_cmp++;
        if (bus.rd_data[1*DW +: DW] !== model[12]) begin
            n_err++;
            $display("FAIL multi_port1_addr12 got %h required %h", bus.rd_data[1*DW +: DW], model[12]);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic          w;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd, e;
        for (int c = 0; c < 300; c++) begin
            w  = 1'($urandom);
            wa = AW'($urandom);
            wd = $urandom;
            bus.we = w; bus.wr_addr = wa; bus.wr_data = wd;
            for (int k = 0; k < NR; k++)
                bus.rd_addr[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
            bus.dbg_addr = AW'($urandom);
            #1;
            for (int k = 0; k < NR; k++) begin
                ra = bus.rd_addr[k*AW +: AW];
                e  = exp_rd(ra, w, wa, wd);
                n_cmp++;
                if (bus.rd_data[k*DW +: DW] !== e) begin
                    n_err++;
                    $display("FAIL random_rd%0d cyc=%0d addr=%0d got %h required %h",
                             k, c, ra, bus.rd_data[k*DW +: DW], e);
                end
            end
            n_cmp++;
            if (bus.dbg_data !== model[bus.dbg_addr]) begin
                n_err++;
                $display("FAIL random_dbg cyc=%0d got %h required %h", c, bus.dbg_data, model[bus.dbg_addr]);
            end
            @(negedge clk);
            if (w && !(ZERO && wa == 0)) model[wa] = wd;
        end
        bus.we = 1'b0;
    endtask

    task automatic test_clear();
        int n, bad;
        bus.we = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h1234;
        @(negedge clk);
        model[7] = 32'h1234;
        bus.we = 1'b1; bus.wr_addr = 5'd8; bus.wr_data = ~model[8]; bus.clr = 1'b1;
        @(negedge clk);
        bus.we = 1'b0; bus.clr = 1'b0; bus.dbg_addr = 5'd8;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL clear_start busy=%b required 1", bus.busy);
        end
        n_cmp++;
        if (bus.dbg_data !== model[8]) begin
            n_err++;
            $display("FAIL clear_write_discard got %h required %h", bus.dbg_data, model[8]);
        end
        wait_sweep(10, n, bad);
        n_cmp++;
        if (n !== 32) begin
            n_err++;
            $display("FAIL clear_sweep_len got %0d required 32", n);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL clear_busy_mask got %0d bad cycles required 0", bad);
        end
        for (int a = 0; a < DEPTH; a++) begin
            bus.dbg_addr = AW'(a);
            #1;
            n_cmp++;
            if (bus.dbg_data !== '0) begin
                n_err++;
                $display("FAIL clear_dbg addr=%0d got %h required 0", a, bus.dbg_data);
            end
        end
    endtask

    task automatic test_rst_mid();
        int n, bad;
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_state busy=%b wr_ready=%b required busy=1 wr_ready=0", bus.busy, bus.wr_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        wait_sweep(-1, n, bad);
        n_cmp++;
        if (n !== 32) begin
            n_err++;
            $display("FAIL rst_mid_sweep_len got %0d required 32", n);
        end
    endtask

    task automatic test_zero_reg();
        logic [DW-1:0] e;
        e = ZERO ? 32'h0 : 32'hFFFF_FFFF;
        bus.we = 1'b1; bus.wr_addr = '0; bus.wr_data = 32'hFFFF_FFFF;
        bus.rd_addr = '0; bus.dbg_addr = '0;
        #1;
        n_cmp++;
        if (bus.wr_ready !== 1'b1 || bus.rd_data[0 +: DW] !== e) begin
            n_err++;
            $display("FAIL zero_reg_same_cycle rd=%h wr_ready=%b required rd=%h wr_ready=1",
                     bus.rd_data[0 +: DW], bus.wr_ready, e);
        end
        @(negedge clk);
        bus.we = 1'b0;
        #1;
        n_cmp++;
        if (bus.rd_data[0 +: DW] !== e) begin
            n_err++;
            $display("FAIL zero_reg_after got %h required %h", bus.rd_data[0 +: DW], e);
        end
        n_cmp++;
        if (bus.dbg_data !== e) begin
            n_err++;
            $display("FAIL zero_reg_dbg got %h required %h", bus.dbg_data, e);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.clr = 1'b0; bus.we = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_addr = '0; bus.dbg_addr = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge clk);
        test_reset();
        test_bypass();
        test_multi_port();
        test_random();
        test_clear();
        test_random();
        test_rst_mid();
        test_zero_reg();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
